// File: rtl/uart_rx_if.sv
// Serial-side and word-side signals of the UART receiver, grouped for port connection.
`timescale 1ns/1ps
interface uart_rx_if #(
  parameter int DBIT = 8
) ();
  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            parity_err;

  // master drives the line and tick and consumes received words
  modport master (
    output s_tick, rx,
    input  dout, rx_done_tick, frame_err, parity_err
  );

  modport slave (
    input  s_tick, rx,
    output dout, rx_done_tick, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver, LSB first, DBIT data bits, SB_TICK-tick stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
//
//  state  | meaning
//  IDLE   | line idle, waiting for rx_s low on an s_tick
//  START  | counting to the middle of the start bit, rejecting glitches
//  DATA   | sampling DBIT data bits mid-bit, shifting in LSB first
//  PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
//  STOP   | waiting out the stop bit, then publishing the word
`timescale 1ns/1ps
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input logic     clk,
  input logic     reset,
  uart_rx_if.slave bus
);

  localparam int SMAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_END  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;
  logic            rx_meta, rx_s;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            perr_q, perr_d;
`endif

  // rx is asynchronous to clk
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = perr_q;
`endif
    if (bus.s_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            s_d     = '0;
          end
        end
        START: begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
        DATA: begin
          if (s_q == S_END) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_q == S_END) begin
            par_bad_d = (^b_q) ^ rx_s ^ PAR_ODD;
            s_d       = '0;
            state_d   = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
`endif
        STOP: begin
          if (s_q == S_STOP) begin
            dout_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
          end else begin
            s_d = s_q + SW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // strobe is registered so dout and the error flags are valid in the same cycle
  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_q;
`else
  assign bus.parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: randomized frames compared with a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam int NOMINAL_LAT = (8 + 16*DBIT + SB_TICK + (PEN ? 16 : 0)) * 4 + 2;

  logic clk = 1'b0;
  logic reset;

  uart_rx_if #(.DBIT(DBIT)) bus ();

  uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } frame_t;

  frame_t  got_q[$];
  frame_t  exp_q[$];
  int      checks = 0;
  int      errors = 0;
  int      long_strobes = 0;
  realtime drop_t = 0;
  realtime last_done_t = 0;

  initial begin
    bus.s_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 bus.s_tick = 1'b1;
      @(posedge clk);
      #1 bus.s_tick = 1'b0;
    end
  end

  initial begin : monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rx_done_tick === 1'b1) begin
        got_q.push_back({bus.dout, bus.frame_err, bus.parity_err});
        last_done_t = $realtime;
        if (prev) long_strobes++;
      end
      prev = bus.rx_done_tick;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic wait_tick();
    do @(posedge clk); while (bus.s_tick !== 1'b1);
    #1;
  endtask

  task automatic idle(input int nbits);
    bus.rx = 1'b1;
    repeat (16*nbits) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
    drop_t = $realtime;
    bus.rx = 1'b0;
    repeat (16) wait_tick();
    for (int i = 0; i < DBIT; i++) begin
      bus.rx = data[i];
      repeat (16) wait_tick();
    end
    if (PEN) begin
      bus.rx = par;
      repeat (16) wait_tick();
    end
    bus.rx = stop;
    repeat (SB_TICK) wait_tick();
    bus.rx = 1'b1;
  endtask

  function automatic frame_t model(input logic [7:0] data, input logic stop, input logic par);
    frame_t f;
    f.d  = data;
    f.fe = ~stop;
    f.pe = PEN ? ((^data) ^ par) : 1'b0;
    return f;
  endfunction

  task automatic test_reset();
    reset  = 1'b1;
    bus.rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset dout: got %h expected 00", bus.dout); end
    checks++; if (bus.rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", bus.rx_done_tick); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err: got %b expected 0", bus.frame_err); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset parity_err: got %b expected 0", bus.parity_err); end
    reset = 1'b0;
    idle(2);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL reset idle strobes: got %0d expected 0", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] data;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      data = (i == 0) ? 8'h55 : (i == 1) ? 8'hA3 : 8'($urandom_range(0, 255));
      exp_q.push_back(model(data, 1'b1, ^data));
      send_frame(data, 1'b1, ^data);
    end
    idle(2);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b frame %0d: got d=%h fe=%b pe=%b expected d=%h fe=%b pe=%b",
                   i, got_q[i].d, got_q[i].fe, got_q[i].pe, exp_q[i].d, exp_q[i].fe, exp_q[i].pe);
        end
      end
    end
    checks++; if (long_strobes !== 0) begin errors++; $display("FAIL b2b strobe width: got %0d multi-clk strobes expected 0", long_strobes); end
  endtask

  task automatic test_glitch();
    frame_t e;
    got_q.delete();
    bus.rx = 1'b0;
    repeat (3) wait_tick();
    idle(12);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL glitch strobes: got %0d expected 0", got_q.size()); end
    e = model(8'h0F, 1'b1, ^8'h0F);
    send_frame(8'h0F, 1'b1, ^8'h0F);
    idle(2);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL glitch next count: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++;
      if (got_q[0] !== e) begin errors++; $display("FAIL glitch next frame: got d=%h fe=%b expected d=%h fe=%b", got_q[0].d, got_q[0].fe, e.d, e.fe); end
    end
  endtask

  task automatic test_frame_err();
    got_q.delete(); exp_q.delete();
    exp_q.push_back(model(8'hC4, 1'b0, ^8'hC4));
    send_frame(8'hC4, 1'b0, ^8'hC4);
    idle(2);
    exp_q.push_back(model(8'h11, 1'b1, ^8'h11));
    send_frame(8'h11, 1'b1, ^8'h11);
    idle(2);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL ferr count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL ferr frame %0d: got d=%h fe=%b expected d=%h fe=%b", i, got_q[i].d, got_q[i].fe, exp_q[i].d, exp_q[i].fe);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    frame_t e;
    got_q.delete();
    fork
      send_frame(8'hFF, 1'b1, ^8'hFF);
      begin
        repeat (16 + 16*4 + 8) wait_tick();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL midreset dout: got %h expected 00", bus.dout); end
      end
    join
    idle(2);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL midreset aborted strobes: got %0d expected 0", got_q.size()); end
    e = model(8'h3C, 1'b1, ^8'h3C);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle(2);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL midreset resend count: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++;
      if (got_q[0] !== e) begin errors++; $display("FAIL midreset resend frame: got d=%h expected d=%h", got_q[0].d, e.d); end
    end
  endtask

  task automatic test_latency();
    logic [7:0] data;
    int lat;
    got_q.delete();
    data = 8'($urandom_range(0, 255));
    send_frame(data, 1'b1, ^data);
    idle(1);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL latency count: got %0d expected 1", got_q.size()); end
    lat = int'((last_done_t - drop_t) / 10.0);
    checks++;
    if (lat < NOMINAL_LAT - 4 || lat > NOMINAL_LAT + 4) begin
      errors++;
      $display("FAIL latency clk: got %0d expected %0d +/-4", lat, NOMINAL_LAT);
    end
  endtask

  task automatic test_break();
    int hold;
    got_q.delete(); exp_q.delete();
    // one all-zero frame, then a second frame whose start lies in the break and whose bits are all high
    hold = 170 + (PEN ? 16 : 0);
    exp_q.push_back(model(8'h00, 1'b0, 1'b0));
    exp_q.push_back(model(8'hFF, 1'b1, 1'b1));
    bus.rx = 1'b0;
    repeat (hold) wait_tick();
    idle(12);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL break count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL break frame %0d: got d=%h fe=%b pe=%b expected d=%h fe=%b pe=%b",
                   i, got_q[i].d, got_q[i].fe, got_q[i].pe, exp_q[i].d, exp_q[i].fe, exp_q[i].pe);
        end
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    got_q.delete(); exp_q.delete();
    exp_q.push_back(model(8'h07, 1'b1, 1'b1));
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2);
    exp_q.push_back(model(8'h07, 1'b1, 1'b0));
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL parity count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL parity frame %0d: got d=%h pe=%b expected d=%h pe=%b", i, got_q[i].d, got_q[i].pe, exp_q[i].d, exp_q[i].pe);
        end
      end
    end
  endtask
`endif

  initial begin
    bus.rx = 1'b1;
    reset  = 1'b1;
    test_reset();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_latency();
    test_break();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
